// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key controller: prefix-tracking states and
// the special byte values the keyboard can send.
package ps2_pkg;

  // Where the decoder is within a multi-byte scancode sequence.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  // Keyboard error/overrun markers abort whatever sequence is in progress.
  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Scancode set 2 to ASCII lookup: lowercase letters, digits and space.
// Anything else maps to 00.
module ps2_ascii_rom (
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  // Pure lookup table; the caller registers the code, so no storage here.
  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = 8'h61; // a
      8'h32: ascii = 8'h62; // b
      8'h21: ascii = 8'h63; // c
      8'h23: ascii = 8'h64; // d
      8'h24: ascii = 8'h65; // e
      8'h2B: ascii = 8'h66; // f
      8'h34: ascii = 8'h67; // g
      8'h33: ascii = 8'h68; // h
      8'h43: ascii = 8'h69; // i
      8'h3B: ascii = 8'h6A; // j
      8'h42: ascii = 8'h6B; // k
      8'h4B: ascii = 8'h6C; // l
      8'h3A: ascii = 8'h6D; // m
      8'h31: ascii = 8'h6E; // n
      8'h44: ascii = 8'h6F; // o
      8'h4D: ascii = 8'h70; // p
      8'h15: ascii = 8'h71; // q
      8'h2D: ascii = 8'h72; // r
      8'h1B: ascii = 8'h73; // s
      8'h2C: ascii = 8'h74; // t
      8'h3C: ascii = 8'h75; // u
      8'h2A: ascii = 8'h76; // v
      8'h1D: ascii = 8'h77; // w
      8'h22: ascii = 8'h78; // x
      8'h35: ascii = 8'h79; // y
      8'h1A: ascii = 8'h7A; // z
      8'h45: ascii = 8'h30; // 0
      8'h16: ascii = 8'h31; // 1
      8'h1E: ascii = 8'h32; // 2
      8'h26: ascii = 8'h33; // 3
      8'h25: ascii = 8'h34; // 4
      8'h2E: ascii = 8'h35; // 5
      8'h36: ascii = 8'h36; // 6
      8'h3D: ascii = 8'h37; // 7
      8'h3E: ascii = 8'h38; // 8
      8'h46: ascii = 8'h39; // 9
      8'h29: ascii = 8'h20; // space
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Turns the PS/2 byte stream into make/break key events: tracks E0/F0
// prefixes, holds the last pressed key, counts new presses and flags
// protocol errors (prefix timeout, bad prefix order, keyboard error bytes).
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic             key_down,
  output logic             key_press,
  output logic             key_release,
  output logic [CNT_W-1:0] press_cnt,
  output logic             disp_en,
  output logic             proto_err
);

  localparam int unsigned    TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  ps2_state_t        state_reg, state_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic [7:0]        code_reg, code_next;
  logic              ext_reg, ext_next;
  logic              down_reg, down_next;
  logic              press_reg, press_next;
  logic              release_reg, release_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              err_reg, err_next;

  // Decoded event from the current byte, applied to the held-key registers.
  logic              ev_make;
  logic              ev_break;
  logic              ev_ext;
  logic              held_match;
  logic [7:0]        rom_ascii;

  // Registered state: FSM, timeout counter, held key, pulses and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      to_cnt_reg  <= '0;
      code_reg    <= 8'h00;
      ext_reg     <= 1'b0;
      down_reg    <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      to_cnt_reg  <= to_cnt_next;
      code_reg    <= code_next;
      ext_reg     <= ext_next;
      down_reg    <= down_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      cnt_reg     <= cnt_next;
      err_reg     <= err_next;
    end
  end

  // Prefix sequencing, timeout and key-event application.
  always_comb begin
    state_next   = state_reg;
    to_cnt_next  = to_cnt_reg;
    code_next    = code_reg;
    ext_next     = ext_reg;
    down_next    = down_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    cnt_next     = cnt_reg;
    err_next     = err_reg;
    ev_make      = 1'b0;
    ev_break     = 1'b0;
    ev_ext       = 1'b0;

    if (kbd_valid) begin
      // Any accepted byte restarts the prefix timeout, including one that
      // arrives in the very cycle the timeout would have fired.
      to_cnt_next = '0;
      if (is_err_byte(kbd_data)) begin
        err_next   = 1'b1;
        state_next = ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (kbd_data == PS2_EXT)      state_next = ST_EXT;
            else if (kbd_data == PS2_BRK) state_next = ST_BRK;
            else                          ev_make    = 1'b1;
          end
          ST_EXT: begin
            if (kbd_data == PS2_BRK) begin
              state_next = ST_EXT_BRK;
            end else if (kbd_data == PS2_EXT) begin
              err_next   = 1'b1;          // repeated E0: flag but keep waiting
            end else begin
              ev_make    = 1'b1;
              ev_ext     = 1'b1;
              state_next = ST_IDLE;
            end
          end
          ST_BRK, ST_EXT_BRK: begin
            state_next = ST_IDLE;
            if (kbd_data == PS2_EXT || kbd_data == PS2_BRK) begin
              err_next = 1'b1;
            end else begin
              ev_break = 1'b1;
              ev_ext   = (state_reg == ST_EXT_BRK);
            end
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end else if (state_reg != ST_IDLE) begin
      if (to_cnt_reg == TO_LAST) begin
        err_next    = 1'b1;
        state_next  = ST_IDLE;
        to_cnt_next = '0;
      end else begin
        to_cnt_next = to_cnt_reg + 1'b1;
      end
    end else begin
      to_cnt_next = '0;
    end

    held_match = down_reg && (ev_ext == ext_reg) && (kbd_data == code_reg);

    // A make of the key already held is typematic repeat and changes nothing.
    if (ev_make && !held_match) begin
      code_next  = kbd_data;
      ext_next   = ev_ext;
      down_next  = 1'b1;
      press_next = 1'b1;
      cnt_next   = cnt_reg + 1'b1;
    end

    // Only the release of the held key matters; the code stays for display.
    if (ev_break && held_match) begin
      down_next    = 1'b0;
      release_next = 1'b1;
    end
  end

  ps2_ascii_rom u_ascii_rom (
    .code  (code_reg),
    .ascii (rom_ascii)
  );

  assign key_code    = code_reg;
  assign key_ext     = ext_reg;
  assign key_ascii   = ext_reg ? 8'h00 : rom_ascii;
  assign key_down    = down_reg;
  assign key_press   = press_reg;
  assign key_release = release_reg;
  assign press_cnt   = cnt_reg;
  assign disp_en     = down_reg;
  assign proto_err   = err_reg;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Randomized self-checking bench for ps2_key_ctrl against a byte-level
// reference model that keeps the pending prefix bytes in a queue.
module tb_ps2_key_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kbd_data = 8'h00;
  logic       kbd_valid = 1'b0;
  logic [7:0] key_code;
  logic       key_ext;
  logic [7:0] key_ascii;
  logic       key_down;
  logic       key_press;
  logic       key_release;
  logic [7:0] press_cnt;
  logic       disp_en;
  logic       proto_err;

  int n_checks = 0;
  int n_errors = 0;

  ps2_key_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .kbd_data    (kbd_data),
    .kbd_valid   (kbd_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_ascii   (key_ascii),
    .key_down    (key_down),
    .key_press   (key_press),
    .key_release (key_release),
    .press_cnt   (press_cnt),
    .disp_en     (disp_en),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  // Scancode set 2 tables, letters a..z and digits 0..9 in order.
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  logic [7:0] extra_codes [5] = '{8'h29, 8'h5A, 8'h76, 8'h05, 8'h66};

  // Reference model state.
  logic [7:0] m_code, m_cnt;
  logic       m_ext, m_down, m_press, m_release, m_err;
  logic [7:0] pend[$];

  function automatic logic [7:0] ascii_of(input logic [7:0] c);
    for (int i = 0; i < 26; i++) if (c == letter_codes[i]) return 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) if (c == digit_codes[i]) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    return 8'h00;
  endfunction

  function automatic logic [7:0] rand_code();
    int k;
    k = $urandom_range(0, 40);
    if (k < 26) return letter_codes[k];
    if (k < 36) return digit_codes[k - 26];
    return extra_codes[k - 36];
  endfunction

  task automatic model_reset();
    m_code = 8'h00; m_cnt = 8'h00; m_ext = 1'b0; m_down = 1'b0;
    m_press = 1'b0; m_release = 1'b0; m_err = 1'b0;
    pend.delete();
  endtask

  function automatic logic pend_has(input logic [7:0] b);
    foreach (pend[i]) if (pend[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Decode one byte: prefixes accumulate in pend, a code byte completes an event.
  task automatic model_byte(input logic [7:0] b);
    logic ext, brk, same;
    m_press = 1'b0;
    m_release = 1'b0;
    if (b == 8'h00 || b == 8'hFF) begin
      m_err = 1'b1;
      pend.delete();
    end else if (b == 8'hE0) begin
      if (pend.size() == 0) pend.push_back(b);
      else if (pend.size() == 1 && pend[0] == 8'hE0) m_err = 1'b1;
      else begin m_err = 1'b1; pend.delete(); end
    end else if (b == 8'hF0) begin
      if (pend.size() == 0 || (pend.size() == 1 && pend[0] == 8'hE0)) pend.push_back(b);
      else begin m_err = 1'b1; pend.delete(); end
    end else begin
      ext = pend_has(8'hE0);
      brk = pend_has(8'hF0);
      pend.delete();
      same = m_down && (ext == m_ext) && (b == m_code);
      if (!brk && !same) begin
        m_code = b; m_ext = ext; m_down = 1'b1; m_press = 1'b1;
        m_cnt = m_cnt + 8'd1;
      end else if (brk && same) begin
        m_down = 1'b0; m_release = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("key_code", key_code, m_code);
    chk("key_ext", key_ext, m_ext);
    chk("key_ascii", key_ascii, m_ext ? 8'h00 : ascii_of(m_code));
    chk("key_down", key_down, m_down);
    chk("disp_en", disp_en, m_down);
    chk("key_press", key_press, m_press);
    chk("key_release", key_release, m_release);
    chk("press_cnt", press_cnt, m_cnt);
    chk("proto_err", proto_err, m_err);
  endtask

  // All tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b);
    kbd_valid = 1'b1;
    kbd_data  = b;
    @(negedge clk);
    kbd_valid = 1'b0;
    kbd_data  = 8'($urandom);
    model_byte(b);
    $display("byte %02h -> code=%02h ext=%0b asc=%02h down=%0b prs=%0b rel=%0b cnt=%0d err=%0b",
             b, key_code, key_ext, key_ascii, key_down, key_press, key_release, press_cnt, proto_err);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m_press = 1'b0;
      m_release = 1'b0;
      check_all();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    kbd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    $display("reset");
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    logic       e;
    model_reset();
    @(negedge clk);
    do_reset();

    // Basic make with ASCII.
    send_byte(8'h1C);
    chk("t1_ascii", key_ascii, 8'h61);
    chk("t1_cnt", press_cnt, 8'd1);
    // Typematic repeats, then release.
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    chk("t2_rel", key_release, 1'b1);
    chk("t2_cnt", press_cnt, 8'd1);
    idle(1);
    // Extended make/break.
    send_byte(8'hE0); send_byte(8'h75);
    chk("t3_ext", key_ext, 1'b1);
    chk("t3_ascii", key_ascii, 8'h00);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    chk("t3_down", key_down, 1'b0);
    // Rollover and non-matching break.
    send_byte(8'h1C); send_byte(8'h32);
    chk("t4_code", key_code, 8'h32);
    send_byte(8'hF0); send_byte(8'h1C);
    chk("t4_down", key_down, 1'b1);
    idle(2);

    // Timeout: clean just before expiry, sticky error after.
    do_reset();
    send_byte(8'hE0);
    idle(TO - 1);
    pend.delete();
    m_err = 1'b1;
    idle(1);
    chk("t5_err", proto_err, 1'b1);
    send_byte(8'h1C);
    chk("t5_make", key_down, 1'b1);

    // Byte arriving on the expiry cycle is processed, no error.
    do_reset();
    send_byte(8'hE0);
    idle(TO - 1);
    send_byte(8'h75);
    chk("t5b_noerr", proto_err, 1'b0);

    // Counter wrap over 256 presses.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    end
    chk("t6_wrap", press_cnt, 8'h00);

    // Reset between E0 and 75.
    send_byte(8'hE0);
    do_reset();
    send_byte(8'h75);
    chk("t6_noext", key_ext, 1'b0);

    // Random legal event stream.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (m_down && $urandom_range(0, 3) == 0) begin c = m_code; e = m_ext; end
      else begin c = rand_code(); e = ($urandom_range(0, 3) == 0); end
      if (e) send_byte(8'hE0);
      if ($urandom_range(0, 9) < 4) send_byte(8'hF0);
      send_byte(c);
      idle($urandom_range(0, 2));
    end

    // Random raw bytes including errors and bad prefix orders.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    send_byte(8'hE0);
        2, 3:    send_byte(8'hF0);
        4:       send_byte($urandom_range(0, 1) ? 8'hFF : 8'h00);
        default: send_byte(rand_code());
      endcase
      idle($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
